// File: rtl/up_ramcfg_pkg.sv
// Shared definitions for the config-RAM engine read arbiter: FSM encodings,
// latency limits and a width helper for the round-robin pointer.
package up_ramcfg_pkg;

    typedef enum logic {
        ST_SERVE  = 1'b0,
        ST_BUBBLE = 1'b1
    } arb_state_t;

    localparam int G_LAT_MIN = 1;
    localparam int G_LAT_MAX = 4;

    // Bits needed to index 'value' items; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/up_ramcfg_rdarb_rr_arb_n.sv
// Round-robin priority encoder: first asserted request at or above ptr,
// wrapping modulo G_N. The pointer register lives with the caller.
module rr_arb_n
    import up_ramcfg_pkg::*;
#(
    parameter  int G_N = 4,
    localparam int PW  = clog2(G_N)
) (
    input  logic [G_N-1:0] req,
    input  logic           en,
    input  logic [PW-1:0]  ptr,
    output logic [G_N-1:0] gnt,
    output logic [PW-1:0]  idx,
    output logic           vld
);

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int k = 0; k < G_N; k++) begin
            int c;
            c = int'(ptr) + k;
            if (c >= G_N) c = c - G_N;
            if (en && !vld && req[c]) begin
                gnt[c] = 1'b1;
                idx    = PW'(c);
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/up_ramcfg_rdarb.sv
// Shares the config-RAM engine-0 read port between G_NREQ engines, one read per
// cycle, with a forced idle cycle so a waiting CPU access can reach the macro.
module up_ramcfg_rdarb
    import up_ramcfg_pkg::*;
#(
    parameter int G_NREQ    = 4,
    parameter int G_ADDR    = 10,
    parameter int G_WIDTH   = 32,
    parameter int G_LAT     = 3,
    parameter int G_CPU_GAP = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [G_NREQ-1:0]        req,
    input  logic [G_NREQ*G_ADDR-1:0] ra,
    output logic [G_NREQ-1:0]        gnt,
    output logic [G_NREQ-1:0]        rvld,
    output logic [G_WIDTH-1:0]       rdd,
    input  logic                     cpu_pend,
    output logic                     oeng_re,
    output logic [G_ADDR-1:0]        oeng_ra,
    input  logic [G_WIDTH-1:0]       ieng_rdd,
    output logic                     bubble
);

    localparam int PW = clog2(G_NREQ);

    arb_state_t          state_reg, state_next;
    logic [PW-1:0]       rr_ptr_reg;
    logic [PW-1:0]       win_idx;
    logic                win_vld;
    logic [G_NREQ-1:0]   arb_gnt;
    logic                arb_en;
    logic [7:0]          gap_cnt_reg;
    logic                gap_hit;
    logic [G_ADDR-1:0]   ra_arr [G_NREQ];
    logic [G_NREQ-1:0]   tag_reg [G_LAT];

    generate
        for (genvar gi = 0; gi < G_NREQ; gi++) begin : g_ra
            assign ra_arr[gi] = ra[gi*G_ADDR +: G_ADDR];
        end
    endgenerate

    // Gating with rst keeps the combinational grant quiet while reset is held.
    assign arb_en = (state_reg == ST_SERVE) && !rst;

    rr_arb_n #(.G_N(G_NREQ)) u_arb (
        .req (req),
        .en  (arb_en),
        .ptr (rr_ptr_reg),
        .gnt (arb_gnt),
        .idx (win_idx),
        .vld (win_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_SERVE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_SERVE:  if (gap_hit) state_next = ST_BUBBLE;
            ST_BUBBLE: state_next = ST_SERVE;
            default:   state_next = ST_SERVE;
        endcase
    end

    always_comb begin
        gnt     = '0;
        oeng_re = 1'b0;
        oeng_ra = '0;
        bubble  = 1'b0;
        case (state_reg)
            ST_SERVE: begin
                gnt     = arb_gnt;
                oeng_re = win_vld;
                if (win_vld) oeng_ra = ra_arr[win_idx];
            end
            ST_BUBBLE: bubble = 1'b1;
            default: ;
        endcase
    end

    // Counts consecutive engine reads that happen while the CPU is waiting.
    assign gap_hit = cpu_pend && oeng_re && (gap_cnt_reg == 8'(G_CPU_GAP - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  gap_cnt_reg <= '0;
        else if (!cpu_pend || !oeng_re || gap_hit) gap_cnt_reg <= '0;
        else                                      gap_cnt_reg <= gap_cnt_reg + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (win_vld) begin
            rr_ptr_reg <= (win_idx == PW'(G_NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // One-hot grant tags travel alongside the macro latency to become rvld.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < G_LAT; k++) tag_reg[k] <= '0;
        end else begin
            tag_reg[0] <= gnt;
            for (int k = 1; k < G_LAT; k++) tag_reg[k] <= tag_reg[k-1];
        end
    end

    assign rvld = tag_reg[G_LAT-1];
    assign rdd  = ieng_rdd;

endmodule
